// File: rtl/audio_pkg.sv
// audio_pkg: shared constants, lookup tables and state type for the sound event scheduler
// Event indices double as priorities (higher wins). KEY/DURATION are indexed by event.
package audio_pkg;
  localparam int unsigned EV_SHOT = 0;
  localparam int unsigned EV_ENEMY_DEAD = 1;
  localparam int unsigned EV_PLAYER_HIT = 2;
  localparam int unsigned EV_PLAYER_DEAD = 3;
  localparam logic [3:0] SILENT_KEY = 4'd15;
  localparam logic [3:0] KEY [4] = '{4'd1, 4'd3, 4'd2, 4'd4};
  localparam logic [7:0] DURATION [4] = '{8'd2, 8'd4, 8'd4, 8'd8};
  typedef enum logic [1:0] {IDLE, PLAY, GAP} sched_state_t;
  function automatic logic [3:0] key_of(input int unsigned idx);
    return idx == EV_SHOT ? KEY[0] : idx == EV_ENEMY_DEAD ? KEY[1] :
           idx == EV_PLAYER_HIT ? KEY[2] : idx == EV_PLAYER_DEAD ? KEY[3] : SILENT_KEY;
  endfunction
  // A zero table entry would never expire, so it plays for one tick instead.
  function automatic logic [7:0] dur_of(input int unsigned idx);
    logic [7:0] d;
    d = idx == EV_SHOT ? DURATION[0] : idx == EV_ENEMY_DEAD ? DURATION[1] :
        idx == EV_PLAYER_HIT ? DURATION[2] : idx == EV_PLAYER_DEAD ? DURATION[3] : 8'd1;
    return d == 8'd0 ? 8'd1 : d;
  endfunction
endpackage

// File: rtl/sound_prio_encoder.sv
// sound_prio_encoder: highest-set-index encoder with valid flag
// Ports: req_i request vector; idx_o index of highest set bit; valid_o any bit set.
module sound_prio_encoder #(
  parameter int N = 4,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) if (req_i[i]) idx_o = IW'(i);
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/sound_event_scheduler.sv
// sound_event_scheduler: collects sound event pulses and plays one prioritised key at a time
// Ports: clk, resetN (sync, active-low), tick (slow strobe), event_req (request pulses),
// mute; sound_key/sound_on to the tone generator, busy, pending set, dropped pulse.
// Optional: AUDIO_SCHED_DROP_CNT_EN adds drop_count[7:0], a saturating count of preemptions.
module sound_event_scheduler
  import audio_pkg::*;
#(
  parameter int NUM_EVENTS = 4,
  parameter int DUR_W = 4,
  parameter int GAP_TICKS = 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  tick,
  input  logic [NUM_EVENTS-1:0] event_req,
  input  logic                  mute,
  output logic [3:0]            sound_key,
  output logic                  sound_on,
  output logic                  busy,
  output logic [NUM_EVENTS-1:0] pending,
  output logic                  dropped
`ifdef AUDIO_SCHED_DROP_CNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);
  localparam int IW = NUM_EVENTS > 1 ? $clog2(NUM_EVENTS) : 1;
  localparam logic [DUR_W-1:0] GAP_LD = DUR_W'(GAP_TICKS);
  sched_state_t state_q, state_d;
  logic [IW-1:0] g_q, g_d, top_idx;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [NUM_EVENTS-1:0] pend_q, pend_d, eff, clr;
  logic dropped_q, dropped_d, top_v, preempt, grant, last_tick;
  function automatic logic [NUM_EVENTS-1:0] onehot(input logic [IW-1:0] i);
    return NUM_EVENTS'(1) << i;
  endfunction
  function automatic logic [DUR_W-1:0] dur_ld(input logic [IW-1:0] i);
    return DUR_W'(dur_of(32'(i)));
  endfunction
  // Same-cycle requests join arbitration so a pulse reaches sound_key one clock later.
  assign eff = pend_q | event_req;
  sound_prio_encoder #(.N(NUM_EVENTS), .IW(IW)) u_enc (
    .req_i(eff),
    .idx_o(top_idx),
    .valid_o(top_v)
  );
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    cnt_d = cnt_q;
    dropped_d = 1'b0;
    preempt = state_q == PLAY && top_v && top_idx > g_q;
    grant = (state_q == IDLE && top_v) || preempt;
    // While playing, a request for the current sound is a retrigger and never goes pending.
    clr = grant ? onehot(top_idx) : state_q == PLAY ? onehot(g_q) : '0;
    pend_d = eff & ~clr;
    last_tick = tick && cnt_q <= DUR_W'(1);
    case (state_q)
      IDLE: if (top_v) begin
        state_d = PLAY;
        g_d = top_idx;
        cnt_d = dur_ld(top_idx);
      end
      PLAY: if (preempt) begin
        g_d = top_idx;
        cnt_d = dur_ld(top_idx);
        dropped_d = 1'b1;
      end else if (event_req[g_q]) cnt_d = dur_ld(g_q);
      else if (last_tick) begin
        state_d = GAP_TICKS == 0 ? IDLE : GAP;
        cnt_d = GAP_LD;
      end else if (tick) cnt_d = cnt_q - DUR_W'(1);
      GAP: if (last_tick) begin
        state_d = IDLE;
        cnt_d = '0;
      end else if (tick) cnt_d = cnt_q - DUR_W'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!resetN) begin
      state_q <= IDLE;
      g_q <= '0;
      cnt_q <= '0;
      pend_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      dropped_q <= dropped_d;
    end
  assign sound_on = state_q == PLAY && !mute;
  assign sound_key = sound_on ? key_of(32'(g_q)) : SILENT_KEY;
  assign busy = state_q != IDLE;
  assign pending = pend_q;
  assign dropped = dropped_q;
`ifdef AUDIO_SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  always_ff @(posedge clk)
    if (!resetN) drop_cnt_q <= '0;
    else if (dropped_d && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
  assign drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_sound_event_scheduler.sv
// tb_sound_event_scheduler: directed and randomized checks against a behavioural model
module tb_sound_event_scheduler;
  localparam int GAP = 1;
  localparam int DURS [4] = '{2, 4, 4, 8};
  localparam int KEYS [4] = '{1, 3, 2, 4};
  logic clk = 0, resetN = 0, tick = 0, mute = 0;
  logic [3:0] event_req = '0;
  logic [3:0] sound_key, pending;
  logic sound_on, busy, dropped;
  int n_cmp = 0, n_bad = 0;
  int m_mode = 0, m_cur = 0, m_rem = 0, m_dcnt = 0;
  logic [3:0] m_pend = '0;
  logic m_drop = 0;
`ifdef AUDIO_SCHED_DROP_CNT_EN
  logic [7:0] drop_count;
`endif
  sound_event_scheduler dut (
    .clk(clk), .resetN(resetN), .tick(tick), .event_req(event_req), .mute(mute),
    .sound_key(sound_key), .sound_on(sound_on), .busy(busy), .pending(pending), .dropped(dropped)
`ifdef AUDIO_SCHED_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );
  always #5 clk = ~clk;
  // mode: 0 silent/idle, 1 a sound is sounding, 2 trailing silence; rem = ticks still owed
  task automatic model(input logic [3:0] r, input logic t, input logic rn);
    logic [3:0] all;
    int top;
    m_drop = 0;
    if (!rn) begin
      m_mode = 0; m_pend = '0; m_rem = 0; m_cur = 0; m_dcnt = 0;
      return;
    end
    all = m_pend | r;
    top = -1;
    for (int i = 0; i < 4; i++) if (all[i]) top = i;
    m_pend = all;
    if (m_mode == 0) begin
      if (top >= 0) begin
        m_pend[top] = 0; m_cur = top; m_rem = DURS[top]; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (top > m_cur) begin
        m_pend[top] = 0; m_cur = top; m_rem = DURS[top]; m_drop = 1;
        if (m_dcnt < 255) m_dcnt++;
      end else begin
        m_pend[m_cur] = 0;
        if (r[m_cur]) m_rem = DURS[m_cur];
        else if (t) begin
          m_rem--;
          if (m_rem == 0) begin
            m_mode = GAP == 0 ? 0 : 2; m_rem = GAP;
          end
        end
      end
    end else if (t) begin
      m_rem--;
      if (m_rem == 0) m_mode = 0;
    end
  endtask
  function automatic logic [10:0] exp_vec();
    logic [3:0] k;
    logic on;
    on = m_mode == 1 && !mute;
    k = on ? 4'(KEYS[m_cur]) : 4'd15;
    return {k, on, m_mode != 0, m_pend, m_drop};
  endfunction
  function automatic logic [10:0] obs_vec();
    return {sound_key, sound_on, busy, pending, dropped};
  endfunction
  task automatic step(input logic [3:0] r, input logic t, input logic m, input logic rn);
    @(negedge clk);
    event_req = r; tick = t; mute = m; resetN = rn;
    @(posedge clk);
    model(r, t, rn);
    #1;
  endtask
  task automatic test_reset();
    step(4'h0, 1, 0, 0);
    step(4'h0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(4'h0, i[0], 0, 1);
      n_cmp++;
      if ({sound_key, sound_on, busy, dropped} !== {4'd15, 3'b000}) begin
        n_bad++; $display("FAIL reset_idle cyc%0d got key=%0d on=%b busy=%b drop=%b want 15/0/0/0", i, sound_key, sound_on, busy, dropped);
      end
    end
  endtask
  task automatic test_single_shot();
    step(4'b0001, 0, 0, 1);
    n_cmp++;
    if ({sound_key, sound_on} !== {4'd1, 1'b1}) begin
      n_bad++; $display("FAIL shot_start got key=%0d on=%b want 1/1", sound_key, sound_on);
    end
    for (int i = 0; i < 8; i++) begin
      step(4'h0, i[0], 0, 1);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL shot cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_simultaneous();
    step(4'b0011, 0, 0, 1);
    n_cmp++;
    if ({sound_key, pending} !== {4'd3, 4'b0001}) begin
      n_bad++; $display("FAIL simul_start got key=%0d pend=%b want 3/0001", sound_key, pending);
    end
    for (int i = 0; i < 12; i++) begin
      step(4'h0, 1, 0, 1);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL simul cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_preempt();
    step(4'b0001, 0, 0, 1);
    step(4'b1000, 1, 0, 1);
    n_cmp++;
    if ({sound_key, dropped} !== {4'd4, 1'b1}) begin
      n_bad++; $display("FAIL preempt got key=%0d drop=%b want 4/1", sound_key, dropped);
    end
    for (int i = 0; i < 12; i++) begin
      step(4'h0, 1, 0, 1);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL preempt_run cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_retrigger();
    int audible;
    step(4'b0010, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(4'h0, 1, 0, 1);
    step(4'b0010, 0, 0, 1);
    n_cmp++;
    if ({dropped, pending} !== 5'b0) begin
      n_bad++; $display("FAIL retrig_req got drop=%b pend=%b want 0/0000", dropped, pending);
    end
    audible = 3;
    for (int i = 0; i < 20 && sound_on; i++) begin
      step(4'h0, 1, 0, 1);
      audible++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL retrig_run cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (audible != 7) begin
      n_bad++; $display("FAIL retrig_len got %0d ticks want 7", audible);
    end
    step(4'h0, 1, 0, 1);
  endtask
  task automatic test_mute();
    step(4'b0100, 0, 1, 1);
    n_cmp++;
    if ({sound_key, sound_on, busy} !== {4'd15, 2'b01}) begin
      n_bad++; $display("FAIL mute_play got key=%0d on=%b busy=%b want 15/0/1", sound_key, sound_on, busy);
    end
    for (int i = 0; i < 4; i++) step(4'h0, 1, 1, 1);
    step(4'h0, 1, 1, 1);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL mute_advance got busy=%b want 0", busy);
    end
  endtask
  task automatic test_reset_mid();
    step(4'b1000, 0, 0, 1);
    step(4'h0, 1, 0, 1);
    step(4'b0001, 1, 0, 1);
    step(4'h0, 0, 0, 0);
    n_cmp++;
    if (obs_vec() !== {4'd15, 7'b0}) begin
      n_bad++; $display("FAIL reset_mid got %h want %h", obs_vec(), {4'd15, 7'b0});
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 5) == 0 ? 4'($urandom) : 4'h0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 99) != 0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
`ifdef AUDIO_SCHED_DROP_CNT_EN
      n_cmp++;
      if (drop_count !== 8'(m_dcnt)) begin
        n_bad++; $display("FAIL drop_count cyc%0d got %0d want %0d", i, drop_count, m_dcnt);
      end
`endif
    end
  endtask
  initial begin
    test_reset();
    test_single_shot();
    test_simultaneous();
    test_preempt();
    test_retrigger();
    test_mute();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
